lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 160 ++++++++++++++++
 tb/tb_lfsr_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Checks a received 16-bit Fibonacci LFSR stream against a local copy of the generator.
// Optional resynchronisation on a burst of consecutive mismatches: define LFSR_CHK_RESYNC_EN.
module lfsr_checker #(
  parameter logic [15:0] SEED          = 16'hAAAA,
  parameter int          RESYNC_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_cmd,
  input  logic [15:0] datain,
  input  logic        clr,
  output logic        err_pulse,
  output logic        in_sync,
  output logic [31:0] word_cnt,
  output logic [15:0] err_cnt,
  output logic        first_err_seen,
  output logic [15:0] first_err_data,
  output logic [15:0] first_err_exp
);

  typedef enum logic {
    ST_CHECK = 1'b0,
    ST_SYNC  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] exp_reg, exp_next;
  logic [31:0] word_cnt_reg, word_cnt_next;
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic        err_pulse_reg, err_pulse_next;
  logic        first_seen_reg, first_seen_next;
  logic [15:0] first_data_reg, first_data_next;
  logic [15:0] first_exp_reg, first_exp_next;

  // Word the generator should emit next: exp_reg advanced by one step.
  logic [15:0] exp_adv;
  logic        mismatch;

  assign exp_adv[0] = exp_reg[4] ^ exp_reg[10] ^ exp_reg[14] ^ exp_reg[15];

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_shift
      assign exp_adv[gi] = exp_reg[gi-1];
    end
  endgenerate

  assign mismatch = (datain != exp_adv);

`ifdef LFSR_CHK_RESYNC_EN
  localparam int CONSEC_W = $clog2(RESYNC_THRESH + 1);

  logic [CONSEC_W-1:0] consec_reg, consec_next, consec_inc;

  assign consec_inc = consec_reg + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      consec_reg <= '0;
    end else begin
      consec_reg <= consec_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_CHECK;
      exp_reg        <= SEED;
      word_cnt_reg   <= '0;
      err_cnt_reg    <= '0;
      err_pulse_reg  <= 1'b0;
      first_seen_reg <= 1'b0;
      first_data_reg <= '0;
      first_exp_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      exp_reg        <= exp_next;
      word_cnt_reg   <= word_cnt_next;
      err_cnt_reg    <= err_cnt_next;
      err_pulse_reg  <= err_pulse_next;
      first_seen_reg <= first_seen_next;
      first_data_reg <= first_data_next;
      first_exp_reg  <= first_exp_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    exp_next        = exp_reg;
    word_cnt_next   = word_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    err_pulse_next  = 1'b0;
    first_seen_next = first_seen_reg;
    first_data_next = first_data_reg;
    first_exp_next  = first_exp_reg;
`ifdef LFSR_CHK_RESYNC_EN
    consec_next     = consec_reg;
`endif

    // clr wins over a coincident word, which is dropped.
    if (clr) begin
      state_next      = ST_CHECK;
      exp_next        = SEED;
      word_cnt_next   = '0;
      err_cnt_next    = '0;
      first_seen_next = 1'b0;
      first_data_next = '0;
      first_exp_next  = '0;
`ifdef LFSR_CHK_RESYNC_EN
      consec_next     = '0;
`endif
    end else if (wr_cmd) begin
      case (state_reg)
        ST_CHECK: begin
          exp_next      = exp_adv;
          word_cnt_next = word_cnt_reg + 32'd1;
          if (mismatch) begin
            err_pulse_next = 1'b1;
            if (err_cnt_reg != 16'hFFFF) begin
              err_cnt_next = err_cnt_reg + 16'd1;
            end
            if (!first_seen_reg) begin
              first_seen_next = 1'b1;
              first_data_next = datain;
              first_exp_next  = exp_adv;
            end
`ifdef LFSR_CHK_RESYNC_EN
            if (consec_inc == CONSEC_W'(RESYNC_THRESH)) begin
              consec_next = '0;
              state_next  = ST_SYNC;
            end else begin
              consec_next = consec_inc;
            end
          end else begin
            consec_next = '0;
`endif
          end
        end
        ST_SYNC: begin
          // Reseed from the incoming word; it is neither compared nor counted.
          exp_next   = datain;
          state_next = ST_CHECK;
        end
        default: begin
          state_next = ST_CHECK;
        end
      endcase
    end
  end

  assign err_pulse      = err_pulse_reg;
  assign in_sync        = (state_reg == ST_CHECK);
  assign word_cnt       = word_cnt_reg;
  assign err_cnt        = err_cnt_reg;
  assign first_err_seen = first_seen_reg;
  assign first_err_data = first_data_reg;
  assign first_err_exp  = first_exp_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised self-checking bench for lfsr_checker against a behavioural stream model.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_cmd = 1'b0;
  logic [15:0] datain = '0;
  logic        clr = 1'b0;
  logic        err_pulse, in_sync, first_err_seen;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt, first_err_data, first_err_exp;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_exp;
  logic [31:0] m_words;
  int          m_errs;
  logic        m_pulse, m_seen, m_insync;
  logic [15:0] m_fdata, m_fexp;
  int          m_consec;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .datain(datain), .clr(clr),
    .err_pulse(err_pulse), .in_sync(in_sync), .word_cnt(word_cnt), .err_cnt(err_cnt),
    .first_err_seen(first_err_seen), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v >> 4) ^ (v >> 10) ^ (v >> 14) ^ (v >> 15)) & 1;
    return 16'((v * 2 + fb) % 65536);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = 16'hAAAA; m_words = 0; m_errs = 0; m_pulse = 0; m_seen = 0;
    m_fdata = 0; m_fexp = 0; m_insync = 1; m_consec = 0;
  endtask

  task automatic model_update(input logic w, input logic [15:0] d, input logic c);
    logic [15:0] want;
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else if (w) begin
      if (!m_insync) begin
        m_exp = d;
        m_insync = 1;
      end else begin
        want = lfsr_next(m_exp);
        m_exp = want;
        m_words = m_words + 1;
        if (d != want) begin
          m_pulse = 1;
          if (m_errs < 65535) m_errs++;
          if (!m_seen) begin
            m_seen = 1; m_fdata = d; m_fexp = want;
          end
`ifdef LFSR_CHK_RESYNC_EN
          m_consec++;
          if (m_consec == 4) begin
            m_consec = 0;
            m_insync = 0;
          end
        end else begin
          m_consec = 0;
`endif
        end
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    check({ctx, ".in_sync"}, 32'(in_sync), 32'(m_insync));
    check({ctx, ".word_cnt"}, word_cnt, m_words);
    check({ctx, ".err_cnt"}, 32'(err_cnt), 32'(m_errs));
    check({ctx, ".first_seen"}, 32'(first_err_seen), 32'(m_seen));
    check({ctx, ".first_data"}, 32'(first_err_data), 32'(m_fdata));
    check({ctx, ".first_exp"}, 32'(first_err_exp), 32'(m_fexp));
  endtask

  task automatic step(input string ctx, input logic w, input logic [15:0] d, input logic c);
    wr_cmd = w; datain = d; clr = c;
    @(posedge clk);
    model_update(w, d, c);
    #1;
    $display("%s: wr=%0b clr=%0b din=%h -> pulse=%0b sync=%0b words=%0d errs=%0d",
             ctx, w, c, d, err_pulse, in_sync, word_cnt, err_cnt);
    compare_all(ctx);
    wr_cmd = 0; clr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1;
    compare_all("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Clean two-word stream
    step("good0", 1, 16'h5555, 0);
    step("good1", 1, 16'hAAAB, 0);
    check("good.word_cnt_const", word_cnt, 32'd2);

    // Corrupted second word, then a correct third
    do_reset();
    step("bad0", 1, 16'h5555, 0);
    step("bad1", 1, 16'hAAAA, 0);
    check("bad.first_data_const", 32'(first_err_data), 32'h0000AAAA);
    check("bad.first_exp_const", 32'(first_err_exp), 32'h0000AAAB);
    step("bad2", 1, lfsr_next(m_exp), 0);
    step("idle", 0, 16'h1234, 0);

    // clr beats a coincident word
    step("clrw", 1, 16'h5555, 1);
    step("clr_next", 1, 16'h5555, 0);

    // Back-to-back random traffic with corruptions, idles and clears
    for (int i = 0; i < 400; i++) begin
      logic w, c, corrupt;
      logic [15:0] d;
      c       = ($urandom_range(0, 39) == 0);
      w       = ($urandom_range(0, 3) != 0);
      corrupt = ($urandom_range(0, 7) == 0);
      d       = corrupt ? 16'($urandom) : lfsr_next(m_exp);
      step("rand", w, d, c);
    end

    // Asynchronous reset mid-stream, with a garbage word held on the bus
    step("pre_rst", 1, 16'hDEAD, 0);
    wr_cmd = 1; datain = 16'hBEEF;
    rst = 1'b0;
    model_reset();
    #2;
    compare_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b1; wr_cmd = 0;
    compare_all("rst_hold");
    step("post_rst", 1, 16'h5555, 0);

`ifdef LFSR_CHK_RESYNC_EN
    do_reset();
    for (int i = 0; i < 4; i++) step("garbage", 1, lfsr_next(m_exp) ^ 16'h0101, 0);
    check("resync.in_sync_low", 32'(in_sync), 32'd0);
    begin
      logic [15:0] g;
      g = 16'h1234;
      step("reseed", 1, g, 0);
      check("resync.in_sync_high", 32'(in_sync), 32'd1);
      for (int i = 0; i < 6; i++) begin
        g = lfsr_next(g);
        step("gen", 1, g, 0);
      end
    end
`endif

    // Saturate err_cnt: an all-zero word never matches a non-zero LFSR state
    do_reset();
    wr_cmd = 1; datain = 16'h0000;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_update(1, 16'h0000, 0);
    end
    #1;
    $display("saturate: errs=%0d pulse=%0b words=%0d", err_cnt, err_pulse, word_cnt);
    compare_all("saturate");
    wr_cmd = 0;
    step("sat_more", 1, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
